pixel_write_arbiter: RTL and testbench

- Sits directly downstream of the screen-clear sweep engine and directly upstream of the VGA adapter's pixel-write port.
- Sequences whole-screen clears: it enables the sweep engine, captures every (x, y) the engine produces, and writes each one in CLEAR_COLOUR.
- Between clears it accepts sprite pixels (paddles, ball) over a valid/ready handshake, clips them to the screen, and presents one registered write per cycle.

---
 rtl/pixel_write_arbiter_pkg.sv | 19 +
 rtl/pixel_write_arbiter_clip.sv | 59 +++++
 rtl/pixel_write_arbiter.sv | 134 +++++++++++++
 tb/tb_pixel_write_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_write_arbiter_pkg.sv
// Shared constants and types for the pixel write arbiter slice.
package pixel_write_arbiter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'd0;
    localparam logic [COLOUR_W-1:0] WHITE = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        REARM = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_write_arbiter_clip.sv
// In-bounds check and registered write stage shared by the clear and sprite paths.
// A loaded beat appears on vga_* one cycle later; off-screen beats are dropped
// (vga_plot low) and, when they come from the sprite path, counted.
module pixel_clip #(
    parameter int X_W      = pixel_write_arbiter_pkg::X_W,
    parameter int Y_W      = pixel_write_arbiter_pkg::Y_W,
    parameter int COLOUR_W = pixel_write_arbiter_pkg::COLOUR_W,
    parameter int X_MAX    = pixel_write_arbiter_pkg::SCREEN_W - 1,
    parameter int Y_MAX    = pixel_write_arbiter_pkg::SCREEN_H - 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                is_sprite,
    input  logic [X_W-1:0]      in_x,
    input  logic [Y_W-1:0]      in_y,
    input  logic [COLOUR_W-1:0] in_colour,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic [7:0]          clip_count
);
    import pixel_write_arbiter_pkg::*;

    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    logic in_range;

    assign in_range = (in_x <= X_LIM) && (in_y <= Y_LIM);

    // Output register: capture a loaded beat, otherwise hold coordinates and drop the strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (load) begin
            vga_x      <= in_x;
            vga_y      <= in_y;
            vga_colour <= in_colour;
            vga_plot   <= in_range;
        end else begin
            vga_plot   <= 1'b0;
        end
    end

    // Saturating count of off-screen sprite beats.
    always_ff @(posedge clock) begin
        if (reset) begin
            clip_count <= 8'd0;
        end else if (load && is_sprite && !in_range && (clip_count != 8'hFF)) begin
            clip_count <= clip_count + 8'd1;
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Arbitrates the VGA pixel-write port between whole-screen clears driven by the
// sweep engine and sprite pixels arriving over a valid/ready handshake.
//
// state | meaning
// IDLE  | sprite beats accepted; clear_req starts a clear (and wins over a sprite beat)
// CLEAR | sweep engine enabled; every engine coordinate written in CLEAR_COLOUR
// REARM | engine held in reset for one cycle before sprites resume
module pixel_write_arbiter #(
    parameter int X_W          = pixel_write_arbiter_pkg::X_W,
    parameter int Y_W          = pixel_write_arbiter_pkg::Y_W,
    parameter int COLOUR_W     = pixel_write_arbiter_pkg::COLOUR_W,
    parameter int X_MAX        = pixel_write_arbiter_pkg::SCREEN_W - 1,
    parameter int Y_MAX        = pixel_write_arbiter_pkg::SCREEN_H - 1,
    parameter int CLEAR_COLOUR = int'(pixel_write_arbiter_pkg::BLACK)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_req,
    output logic                clr_en,
    input  logic [X_W-1:0]      clr_x,
    input  logic [Y_W-1:0]      clr_y,
    input  logic                clr_done,
    input  logic                spr_valid,
    output logic                spr_ready,
    input  logic [X_W-1:0]      spr_x,
    input  logic [Y_W-1:0]      spr_y,
    input  logic [COLOUR_W-1:0] spr_colour,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                clear_done,
    output logic [7:0]          clip_count
);
    import pixel_write_arbiter_pkg::*;

    localparam logic [COLOUR_W-1:0] CLEAR_COL = COLOUR_W'(CLEAR_COLOUR);

    state_t                state_q;
    state_t                state_d;
    logic                  load;
    logic                  is_sprite;
    logic [X_W-1:0]        pix_x;
    logic [Y_W-1:0]        pix_y;
    logic [COLOUR_W-1:0]   pix_colour;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and source select; reset forces the combinational outputs low
    // so a reset mid-clear drops clr_en in the same cycle.
    always_comb begin
        state_d    = state_q;
        clr_en     = 1'b0;
        spr_ready  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        is_sprite  = 1'b0;
        pix_x      = spr_x;
        pix_y      = spr_y;
        pix_colour = spr_colour;
        case (state_q)
            IDLE: begin
                spr_ready = !clear_req;
                load      = spr_valid && !clear_req;
                is_sprite = 1'b1;
                if (clear_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr_en     = 1'b1;
                busy       = 1'b1;
                load       = 1'b1;
                pix_x      = clr_x;
                pix_y      = clr_y;
                pix_colour = CLEAR_COL;
                if (clr_done) begin
                    state_d = REARM;
                end
            end
            REARM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            clr_en    = 1'b0;
            spr_ready = 1'b0;
            busy      = 1'b0;
            load      = 1'b0;
        end
    end

    // Completion pulse lines up with the output stage: one cycle after the last clear write.
    always_ff @(posedge clock) begin
        if (reset) begin
            clear_done <= 1'b0;
        end else begin
            clear_done <= (state_q == REARM);
        end
    end

    pixel_clip #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOUR_W (COLOUR_W),
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX)
    ) u_clip (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .is_sprite  (is_sprite),
        .in_x       (pix_x),
        .in_y       (pix_y),
        .in_colour  (pix_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .clip_count (clip_count)
    );

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter with a behavioural sweep engine attached.
module tb_pixel_write_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear_req = 1'b0;
    logic       clr_en;
    logic [7:0] clr_x = 8'd0;
    logic [6:0] clr_y = 7'd0;
    logic       clr_done = 1'b0;
    logic       spr_valid = 1'b0;
    logic       spr_ready;
    logic [7:0] spr_x = 8'd0;
    logic [6:0] spr_y = 7'd0;
    logic [2:0] spr_colour = 3'd0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       clear_done;
    logic [7:0] clip_count;

    int checks = 0;
    int errors = 0;

    pixel_write_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .clr_en     (clr_en),
        .clr_x      (clr_x),
        .clr_y      (clr_y),
        .clr_done   (clr_done),
        .spr_valid  (spr_valid),
        .spr_ready  (spr_ready),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_colour (spr_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .clear_done (clear_done),
        .clip_count (clip_count)
    );

    always #5 clock = ~clock;

    // Sweep engine: row-major walk, done raised together with the final coordinate.
    always @(posedge clock) begin
        if (!clr_en) begin
            clr_x    <= 8'd0;
            clr_y    <= 7'd0;
            clr_done <= 1'b0;
        end else if (!clr_done) begin
            if (clr_x == 8'd159) begin
                clr_x <= 8'd0;
                clr_y <= clr_y + 7'd1;
            end else begin
                clr_x <= clr_x + 8'd1;
            end
            clr_done <= (clr_x == 8'd158) && (clr_y == 7'd119);
        end
    end

    // Pulses clear_req now (at a negedge) and follows the clear until clear_done.
    task automatic run_clear(input int mid_at, input bit check_hold);
        int cyc = 0;
        int plots = 0;
        int bad = 0;
        int last_cyc = -1;
        int done_cyc = -1;
        int ex = 0;
        int ey = 0;
        bit seen_busy = 1'b0;
        clear_req = 1'b1;
        #1;
        if (check_hold) begin
            checks++;
            if (spr_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_wins_ready got %b want 0", spr_ready);
            end
        end
        while (done_cyc < 0 && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            clear_req = 1'b0;
            if (vga_plot === 1'b1) begin
                if (vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== 3'd0) begin
                    if (bad == 0)
                        $display("FAIL clear_pixel got (%0d,%0d,%0d) want (%0d,%0d,0)",
                                 vga_x, vga_y, vga_colour, ex, ey);
                    bad++;
                end
                plots++;
                last_cyc = cyc;
                ex++;
                if (ex == 160) begin
                    ex = 0;
                    ey++;
                end
            end
            if (plots == 100 && busy === 1'b1 && clr_en === 1'b1) seen_busy = 1'b1;
            if (clear_done === 1'b1) done_cyc = cyc;
            if (plots == mid_at) clear_req = 1'b1;
        end
        clear_req = 1'b0;
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL clear_timeout got no clear_done want pulse within 20000 cycles");
        end
        checks++;
        if (plots != 19200) begin
            errors++;
            $display("FAIL clear_plot_count got %0d want 19200", plots);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_sequence got %0d bad writes want 0", bad);
        end
        checks++;
        if (done_cyc != last_cyc + 1) begin
            errors++;
            $display("FAIL clear_done_timing got cycle %0d want %0d", done_cyc, last_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_clear got %b want 0", busy);
        end
        checks++;
        if (!seen_busy) begin
            errors++;
            $display("FAIL busy_during_clear got busy=%b clr_en=%b want 1 1", busy, clr_en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({vga_plot, clr_en, busy, clear_done, spr_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {vga_plot, clr_en, busy, clear_done, spr_ready});
        end
        checks++;
        if ({vga_x, vga_y, vga_colour, clip_count} !== 26'd0) begin
            errors++;
            $display("FAIL reset_data got x=%0d y=%0d c=%0d clip=%0d want 0",
                     vga_x, vga_y, vga_colour, clip_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (spr_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready got %b want 1", spr_ready);
        end
    endtask

    task automatic test_full_clear();
        run_clear(-1, 1'b0);
        @(negedge clock);
        checks++;
        if ({clear_done, busy, vga_plot} !== 3'b000) begin
            errors++;
            $display("FAIL post_clear got done=%b busy=%b plot=%b want 000",
                     clear_done, busy, vga_plot);
        end
    endtask

    task automatic test_stream();
        spr_x = 8'd10;
        spr_y = 7'd20;
        spr_colour = 3'd7;
        spr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (vga_plot !== 1'b1 || vga_x !== 8'(10 + i) || vga_y !== 7'd20 || vga_colour !== 3'd7) begin
                errors++;
                $display("FAIL stream_beat%0d got plot=%b (%0d,%0d,%0d) want 1 (%0d,20,7)",
                         i, vga_plot, vga_x, vga_y, vga_colour, 10 + i);
            end
            if (i < 4) spr_x = 8'(11 + i);
            else spr_valid = 1'b0;
        end
        @(negedge clock);
        checks++;
        if (vga_plot !== 1'b0 || vga_x !== 8'd14 || vga_y !== 7'd20) begin
            errors++;
            $display("FAIL stream_hold got plot=%b (%0d,%0d) want 0 (14,20)", vga_plot, vga_x, vga_y);
        end
    endtask

    task automatic test_clip();
        spr_x = 8'd160;
        spr_y = 7'd5;
        spr_colour = 3'd7;
        spr_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL clip_x got plot=%b want 0", vga_plot);
        end
        spr_x = 8'd5;
        spr_y = 7'd120;
        @(negedge clock);
        checks++;
        if (vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL clip_y got plot=%b want 0", vga_plot);
        end
        spr_x = 8'd159;
        spr_y = 7'd119;
        spr_colour = 3'd6;
        @(negedge clock);
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd159 || vga_y !== 7'd119 || vga_colour !== 3'd6) begin
            errors++;
            $display("FAIL clip_corner got plot=%b (%0d,%0d,%0d) want 1 (159,119,6)",
                     vga_plot, vga_x, vga_y, vga_colour);
        end
        spr_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (clip_count !== 8'd2) begin
            errors++;
            $display("FAIL clip_count got %0d want 2", clip_count);
        end
        spr_x = 8'd200;
        spr_y = 7'd0;
        spr_valid = 1'b1;
        repeat (260) @(negedge clock);
        spr_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (clip_count !== 8'd255) begin
            errors++;
            $display("FAIL clip_saturate got %0d want 255", clip_count);
        end
    endtask

    task automatic test_contention();
        spr_x = 8'd30;
        spr_y = 7'd40;
        spr_colour = 3'd5;
        spr_valid = 1'b1;
        run_clear(1000, 1'b1);
        checks++;
        if (spr_ready !== 1'b1) begin
            errors++;
            $display("FAIL held_ready got %b want 1", spr_ready);
        end
        @(negedge clock);
        spr_valid = 1'b0;
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd30 || vga_y !== 7'd40 || vga_colour !== 3'd5) begin
            errors++;
            $display("FAIL held_beat got plot=%b (%0d,%0d,%0d) want 1 (30,40,5)",
                     vga_plot, vga_x, vga_y, vga_colour);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL ignored_req got busy=%b done=%b want 0 0", busy, clear_done);
        end
    endtask

    task automatic test_reset_mid_clear();
        int plots = 0;
        int cyc = 0;
        clear_req = 1'b1;
        while (plots < 500 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            clear_req = 1'b0;
            if (vga_plot === 1'b1) plots++;
        end
        checks++;
        if (plots != 500) begin
            errors++;
            $display("FAIL partial_clear got %0d writes want 500", plots);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({vga_plot, clr_en, busy} !== 3'b000 || clip_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_abort got plot=%b en=%b busy=%b clip=%0d want 0 0 0 0",
                     vga_plot, clr_en, busy, clip_count);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (clr_en !== 1'b0 || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got en=%b plot=%b want 0 0", clr_en, vga_plot);
        end
        run_clear(-1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_clear();
        test_stream();
        test_clip();
        test_contention();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
